// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM:
// state enum, opcodes, mux/ALU select encodings and the control-word struct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_RD    = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WR    = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_ADDI_EXEC = 4'd8,
    ST_ADDI_WB   = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  // Dispatch out of DECODE; anything unrecognised parks the machine in HALT.
  function automatic state_t decode_dispatch(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE:     return ST_R_EXEC;
      OP_LW, OP_SW: return ST_MEM_ADDR;
      OP_ADDI:      return ST_ADDI_EXEC;
      OP_BEQ:       return ST_BRANCH;
      OP_J:         return ST_JUMP;
      default:      return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. master = controller side, slave = datapath side.
// Handshake: memory raises mem_ready in the cycle a requested read/write completes;
// the controller holds mem_read/mem_write and its state until it sees mem_ready=1.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_dest;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             halted;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, halted, retired_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, halted, retired_count
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state (+mem_ready) to control-word decoder for the multi-cycle FSM.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC+4 commit only in the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b1;
      end
      ST_ADDI_WB: ctrl.reg_write = 1'b1;
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and retired-instruction counter.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  logic             retire;
  logic [CNT_W-1:0] count_q;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:     if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = decode_dispatch(bus.opcode);
      ST_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:    if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are masked during reset so an abandoned access never reaches memory or regfile.
  assign bus.pc_write      = ctrl.pc_write      & ~reset;
  assign bus.pc_write_cond = ctrl.pc_write_cond & ~reset;
  assign bus.ir_write      = ctrl.ir_write      & ~reset;
  assign bus.mem_read      = ctrl.mem_read      & ~reset;
  assign bus.mem_write     = ctrl.mem_write     & ~reset;
  assign bus.reg_write     = ctrl.reg_write     & ~reset;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dest      = ctrl.reg_dest;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.halted        = ctrl.halted;
  assign bus.state         = state_q;
  assign bus.retired_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a 32-bit-counter instance plus a 4-bit-counter
// instance run in lockstep on the same inputs.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   ir_pulses = 0;
  int   ld_wb_pulses = 0;
  logic started = 1'b0;

  multicycle_controller_if #(.CNT_W(32)) bus ();
  multicycle_controller_if #(.CNT_W(4))  bus4 ();

  assign bus4.opcode    = bus.opcode;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  multicycle_controller #(.CNT_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
  multicycle_controller #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  logic [5:0] strobes;
  assign strobes = {bus.pc_write, bus.pc_write_cond, bus.ir_write,
                    bus.mem_read, bus.mem_write, bus.reg_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Edge-sampled monitors, away from the active edge.
  always @(negedge clk) begin
    if (bus.ir_write === 1'b1) ir_pulses++;
    if (bus.reg_write === 1'b1 && bus.mem_to_reg === 1'b1) ld_wb_pulses++;
    if (started) chk("rd_wr_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
  end

  initial begin
    reset = 1'b1;
    bus.opcode = OP_RTYPE;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    tick(2);
    chk("reset_strobes", {26'd0, strobes}, 32'd0);
    chk("reset_state", {28'd0, bus.state}, ST_FETCH);
    reset = 1'b0;
    started = 1'b1;
    #1;
    chk("post_reset_count", bus.retired_count, 32'd0);
    chk("post_reset_halted", {31'd0, bus.halted}, 32'd0);

    // R-type, zero wait states: 4 cycles
    chk("r_fetch_strobes", {26'd0, strobes}, 32'b101100);
    chk("r_fetch_srcb", {30'd0, bus.alu_src_b}, 32'b01);
    tick();
    chk("r_decode", {28'd0, bus.state}, ST_DECODE);
    chk("r_decode_srcb", {30'd0, bus.alu_src_b}, 32'b11);
    tick();
    chk("r_exec", {28'd0, bus.state}, ST_R_EXEC);
    chk("r_exec_ctl", {27'd0, bus.alu_src_a, bus.alu_op, bus.reg_write, bus.reg_dest}, 32'b11000);
    tick();
    chk("r_wb", {28'd0, bus.state}, ST_R_WB);
    chk("r_wb_ctl", {29'd0, bus.reg_write, bus.reg_dest, bus.mem_to_reg}, 32'b110);
    tick();
    chk("r_done", {28'd0, bus.state}, ST_FETCH);
    chk("r_count", bus.retired_count, 32'd1);

    // lw with 2 FETCH waits and 3 MEM_RD waits: 10 cycles
    bus.opcode = OP_LW;
    ir_pulses = 0;
    ld_wb_pulses = 0;
    bus.mem_ready = 1'b0;
    #1;
    chk("lw_fetch_wait_ir", {31'd0, bus.ir_write}, 32'd0);
    tick(2);
    chk("lw_fetch_hold", {28'd0, bus.state}, ST_FETCH);
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_fetch_ir", {31'd0, bus.ir_write}, 32'd1);
    tick(2);
    chk("lw_mem_addr", {28'd0, bus.state}, ST_MEM_ADDR);
    chk("lw_addr_srcb", {29'd0, bus.alu_src_a, bus.alu_src_b}, 32'b110);
    bus.mem_ready = 1'b0;
    tick();
    chk("lw_mem_rd", {28'd0, bus.state}, ST_MEM_RD);
    chk("lw_rd_ctl", {30'd0, bus.mem_read, bus.i_or_d}, 32'b11);
    tick(3);
    chk("lw_rd_hold", {28'd0, bus.state}, ST_MEM_RD);
    bus.mem_ready = 1'b1;
    tick();
    chk("lw_mem_wb", {28'd0, bus.state}, ST_MEM_WB);
    chk("lw_wb_ctl", {29'd0, bus.reg_write, bus.mem_to_reg, bus.reg_dest}, 32'b110);
    tick();
    chk("lw_done", {28'd0, bus.state}, ST_FETCH);
    chk("lw_count", bus.retired_count, 32'd2);
    chk("lw_ir_pulses", ir_pulses, 32'd1);
    chk("lw_wb_pulses", ld_wb_pulses, 32'd1);

    // beq taken / not taken: 3 cycles each
    bus.opcode = OP_BEQ;
    bus.zero = 1'b1;
    tick(2);
    chk("beq1_state", {28'd0, bus.state}, ST_BRANCH);
    chk("beq1_ctl", {27'd0, bus.pc_write_cond, bus.pc_source, bus.alu_op}, 32'b10101);
    tick();
    chk("beq1_done", bus.retired_count, 32'd3);
    bus.zero = 1'b0;
    tick(2);
    chk("beq2_ctl", {27'd0, bus.pc_write_cond, bus.pc_source, bus.alu_op}, 32'b10101);
    tick();
    chk("beq2_state", {28'd0, bus.state}, ST_FETCH);
    chk("beq2_count", bus.retired_count, 32'd4);

    // sw and addi, zero wait states: 4 cycles each
    bus.opcode = OP_SW;
    tick(3);
    chk("sw_state", {28'd0, bus.state}, ST_MEM_WR);
    chk("sw_ctl", {29'd0, bus.mem_write, bus.mem_read, bus.i_or_d}, 32'b101);
    tick();
    chk("sw_count", bus.retired_count, 32'd5);
    bus.opcode = OP_ADDI;
    tick(2);
    chk("addi_exec", {28'd0, bus.state}, ST_ADDI_EXEC);
    tick();
    chk("addi_wb_ctl", {29'd0, bus.reg_write, bus.reg_dest, bus.mem_to_reg}, 32'b100);
    tick();
    chk("addi_count", bus.retired_count, 32'd6);

    // Illegal opcode: sticky HALT
    bus.opcode = 6'b111111;
    tick(2);
    chk("halt_state", {28'd0, bus.state}, ST_HALT);
    chk("halt_flag", {31'd0, bus.halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode = (i % 2 == 0) ? OP_RTYPE : OP_J;
      #1;
      chk("halt_strobes", {26'd0, strobes}, 32'd0);
      tick();
    end
    chk("halt_stays", {28'd0, bus.state}, ST_HALT);
    chk("halt_count", bus.retired_count, 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("unhalt_state", {28'd0, bus.state}, ST_FETCH);
    chk("unhalt_flag", {31'd0, bus.halted}, 32'd0);
    chk("unhalt_count", bus.retired_count, 32'd0);

    // Reset while MEM_WR is waiting on memory
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b1;
    tick(3);
    bus.mem_ready = 1'b0;
    #1;
    chk("swr_wait_write", {31'd0, bus.mem_write}, 32'd1);
    tick();
    chk("swr_hold", {28'd0, bus.state}, ST_MEM_WR);
    reset = 1'b1;
    #1;
    chk("swr_reset_write", {31'd0, bus.mem_write}, 32'd0);
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("swr_state", {28'd0, bus.state}, ST_FETCH);
    chk("swr_count", bus.retired_count, 32'd0);

    // 16 jumps: 4-bit counter wraps 15 -> 0
    bus.opcode = OP_J;
    tick(2);
    chk("j_ctl", {29'd0, bus.pc_write, bus.pc_source}, 32'b110);
    tick();
    tick(14 * 3);
    chk("j15_narrow", {28'd0, bus4.retired_count}, 32'd15);
    tick(3);
    chk("j16_narrow_wrap", {28'd0, bus4.retired_count}, 32'd0);
    chk("j16_wide", bus.retired_count, 32'd16);

    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
